updown_counter_mod: RTL

UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

---
 rtl/counter_pkg.sv | 16 +
 rtl/updown_counter_mod_prescaler.sv | 40 ++++
 rtl/updown_counter_mod.sv | 116 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Direction and boundary-mode constants for the up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_counter_mod_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Emits one tick for every PRESCALE cycles with en=1; the
//               divider restarts on sync_clr.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int              c_CW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(PRESCALE - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_last;

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
        end
    end

    // Tick is combinational so the counter steps in the PRESCALE-th en cycle itself.
    assign tick = en && w_last && !sync_clr;

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/updown_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_mod
// Description : Modulo up/down counter with wrap/saturate mode, terminal-count
//               pulse and sticky boundary flag. Define COUNTER_PRESCALE_EN to
//               divide the count enable by PRESCALE.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int          SATURATE = MODE_WRAP,
    parameter int          PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dn,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);
    localparam logic             c_SAT = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_bnd;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_nxt;

`ifdef COUNTER_PRESCALE_EN
    logic w_sync_clr;

    assign w_sync_clr = clr | load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (w_sync_clr),
        .tick     (w_tick)
    );
`else
    assign w_tick = en;
`endif

    assign w_step    = w_tick && !clr && !load;
    assign w_at_max  = (r_count == c_MAX);
    assign w_at_zero = (r_count == '0);
    assign w_bnd     = w_step && ((dn == DIR_DN) ? w_at_zero : w_at_max);

    assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;

    // Boundaries are tested before any arithmetic, so count never exceeds c_MAX.
    always_comb begin
        w_count_nxt = r_count;
        if (clr) begin
            w_count_nxt = '0;
        end else if (load) begin
            w_count_nxt = w_load_clamped;
        end else if (w_step) begin
            if (dn == DIR_UP) begin
                if (w_at_max) begin
                    w_count_nxt = c_SAT ? c_MAX : '0;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_count_nxt = c_SAT ? '0 : c_MAX;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_bnd;
            // A new boundary event wins over a simultaneous clear request.
            if (w_bnd) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule : updown_counter_mod
`default_nettype wire
